time_set_editor: RTL and testbench



---
 rtl/time_set_editor.sv | 227 ++++++++++++++++++++++
 tb/tb_time_set_editor.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/time_set_editor.sv
`default_nettype none
// ============================================================================
// Module      : time_set_editor
// Description : HH:MM digit editor for the set-time path, with a cursor and
//               a blink strobe. Define TIME_SET_DEC_EN to add a dec_button
//               input that decrements the selected digit.
// Revision    : 1.0 - initial release
// ============================================================================
module time_set_editor #(
  parameter int BLINK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [4:0] load_hours,
  input  logic [5:0] load_minutes,
  input  logic       inc_button,
  input  logic       next_button,
`ifdef TIME_SET_DEC_EN
  input  logic       dec_button,
`endif
  output logic [1:0] hours_left,
  output logic [3:0] hours_right,
  output logic [2:0] minutes_left,
  output logic [3:0] minutes_right,
  output logic [1:0] cursor,
  output logic       blink,
  output logic       set_time_ack_flag,
  output logic       set_time_active
);

  localparam int               CNT_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    EDIT_HL = 3'd2,
    EDIT_HR = 3'd3,
    EDIT_ML = 3'd4,
    EDIT_MR = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       hl_q, hl_d;
  logic [3:0]       hr_q, hr_d;
  logic [2:0]       ml_q, ml_d;
  logic [3:0]       mr_q, mr_d;
  logic [1:0]       cursor_q, cursor_d;
  logic             blink_q, blink_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ack_q, ack_d;
  logic             active_q, active_d;

  logic             dec_req;
  logic             step;
  logic             up;
  logic             applied;
  logic             edit_d;
  logic [4:0]       h_in;
  logic [5:0]       m_in;
  logic [1:0]       ld_hl;
  logic [3:0]       ld_hr;
  logic [2:0]       ld_ml;
  logic [3:0]       ld_mr;
  logic [3:0]       hr_limit;

`ifdef TIME_SET_DEC_EN
  assign dec_req = dec_button;
`else
  assign dec_req = 1'b0;
`endif

  // Opposing inc/dec requests cancel; up selects the direction otherwise.
  assign step = inc_button ^ dec_req;
  assign up   = inc_button;

  // Binary to BCD split of the running time, out-of-range fields load as 0.
  always_comb begin
    h_in  = (load_hours <= 5'd23) ? load_hours : 5'd0;
    m_in  = (load_minutes <= 6'd59) ? load_minutes : 6'd0;
    ld_hl = 2'd0;
    ld_hr = h_in[3:0];
    if (h_in >= 5'd20) begin
      ld_hl = 2'd2;
      ld_hr = 4'(h_in - 5'd20);
    end else if (h_in >= 5'd10) begin
      ld_hl = 2'd1;
      ld_hr = 4'(h_in - 5'd10);
    end
    ld_ml = 3'd0;
    ld_mr = m_in[3:0];
    for (int k = 1; k <= 5; k++) begin
      if (m_in >= 6'(10 * k)) begin
        ld_ml = 3'(k);
        ld_mr = 4'(m_in - 6'(10 * k));
      end
    end
  end

  assign hr_limit = (hl_q == 2'd2) ? 4'd3 : 4'd9;

  always_comb begin
    state_d  = state_q;
    hl_d     = hl_q;
    hr_d     = hr_q;
    ml_d     = ml_q;
    mr_d     = mr_q;
    active_d = active_q;
    applied  = 1'b0;

    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = LOAD;
        LOAD: begin
          hl_d     = ld_hl;
          hr_d     = ld_hr;
          ml_d     = ld_ml;
          mr_d     = ld_mr;
          active_d = 1'b0;
          state_d  = EDIT_HL;
        end
        EDIT_HL: begin
          if (step) begin
            applied = 1'b1;
            if (up) hl_d = (hl_q == 2'd2) ? 2'd0 : hl_q + 2'd1;
            else    hl_d = (hl_q == 2'd0) ? 2'd2 : hl_q - 2'd1;
            // Landing on 2x must keep the units digit within 20..23.
            if (hl_d == 2'd2 && hr_q > 4'd3) hr_d = 4'd3;
          end
          if (next_button) state_d = EDIT_HR;
        end
        EDIT_HR: begin
          if (step) begin
            applied = 1'b1;
            if (up) hr_d = (hr_q >= hr_limit) ? 4'd0 : hr_q + 4'd1;
            else    hr_d = (hr_q == 4'd0) ? hr_limit : hr_q - 4'd1;
          end
          if (next_button) state_d = EDIT_ML;
        end
        EDIT_ML: begin
          if (step) begin
            applied = 1'b1;
            if (up) ml_d = (ml_q >= 3'd5) ? 3'd0 : ml_q + 3'd1;
            else    ml_d = (ml_q == 3'd0) ? 3'd5 : ml_q - 3'd1;
          end
          if (next_button) state_d = EDIT_MR;
        end
        EDIT_MR: begin
          if (step) begin
            applied = 1'b1;
            if (up) mr_d = (mr_q >= 4'd9) ? 4'd0 : mr_q + 4'd1;
            else    mr_d = (mr_q == 4'd0) ? 4'd9 : mr_q - 4'd1;
          end
          if (next_button) state_d = DONE;
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
      if (applied) active_d = 1'b1;
    end
  end

  // Cursor, ack and blink are computed from the next state so they register
  // in the same cycle as the state they describe.
  always_comb begin
    edit_d = state_d inside {EDIT_HL, EDIT_HR, EDIT_ML, EDIT_MR};
    ack_d  = (state_d == DONE);
    case (state_d)
      EDIT_HR: cursor_d = 2'd1;
      EDIT_ML: cursor_d = 2'd2;
      EDIT_MR: cursor_d = 2'd3;
      default: cursor_d = 2'd0;
    endcase
    cnt_d   = cnt_q;
    blink_d = blink_q;
    if (!edit_d || state_d != state_q || applied) begin
      cnt_d   = '0;
      blink_d = 1'b0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      blink_d = ~blink_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      hl_q     <= '0;
      hr_q     <= '0;
      ml_q     <= '0;
      mr_q     <= '0;
      cursor_q <= '0;
      blink_q  <= 1'b0;
      cnt_q    <= '0;
      ack_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hl_q     <= hl_d;
      hr_q     <= hr_d;
      ml_q     <= ml_d;
      mr_q     <= mr_d;
      cursor_q <= cursor_d;
      blink_q  <= blink_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      active_q <= active_d;
    end
  end

  assign hours_left        = hl_q;
  assign hours_right       = hr_q;
  assign minutes_left      = ml_q;
  assign minutes_right     = mr_q;
  assign cursor            = cursor_q;
  assign blink             = blink_q;
  assign set_time_ack_flag = ack_q;
  assign set_time_active   = active_q;

endmodule
`default_nettype wire

// File: tb/tb_time_set_editor.sv
`default_nettype none
// ============================================================================
// Module      : tb_time_set_editor
// Description : Directed self-checking bench for time_set_editor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_time_set_editor;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [4:0] load_hours;
  logic [5:0] load_minutes;
  logic       inc_button;
  logic       next_button;
  logic       dec_button;
  logic [1:0] hours_left;
  logic [3:0] hours_right;
  logic [2:0] minutes_left;
  logic [3:0] minutes_right;
  logic [1:0] cursor;
  logic       blink;
  logic       set_time_ack_flag;
  logic       set_time_active;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  time_set_editor #(.BLINK_DIV(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .en               (en),
    .load_hours       (load_hours),
    .load_minutes     (load_minutes),
    .inc_button       (inc_button),
    .next_button      (next_button),
`ifdef TIME_SET_DEC_EN
    .dec_button       (dec_button),
`endif
    .hours_left       (hours_left),
    .hours_right      (hours_right),
    .minutes_left     (minutes_left),
    .minutes_right    (minutes_right),
    .cursor           (cursor),
    .blink            (blink),
    .set_time_ack_flag(set_time_ack_flag),
    .set_time_active  (set_time_active)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_dig(input string tag, input int a, input int b, input int c, input int d);
    chk({tag, " HL"}, 32'(hours_left), 32'(a));
    chk({tag, " HR"}, 32'(hours_right), 32'(b));
    chk({tag, " ML"}, 32'(minutes_left), 32'(c));
    chk({tag, " MR"}, 32'(minutes_right), 32'(d));
  endtask

  task automatic press(input logic inc, input logic nxt);
    inc_button  = inc;
    next_button = nxt;
    tick();
    inc_button  = 1'b0;
    next_button = 1'b0;
  endtask

  // Drops en for one cycle, then raises it with the given load values and
  // steps through LOAD into EDIT_HL.
  task automatic start(input int h, input int m);
    en = 1'b0;
    tick();
    load_hours   = 5'(h);
    load_minutes = 6'(m);
    en = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load_hours = '0; load_minutes = '0;
    inc_button = 1'b0; next_button = 1'b0; dec_button = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk_dig("reset", 0, 0, 0, 0);
    chk("reset cursor", 32'(cursor), 0);
    chk("reset blink", 32'(blink), 0);
    chk("reset ack", 32'(set_time_ack_flag), 0);
    chk("reset active", 32'(set_time_active), 0);

    // Load 13:47: LOAD cycle first, digits valid one cycle later.
    load_hours = 5'd13; load_minutes = 6'd47; en = 1'b1;
    tick();
    chk("in LOAD HL", 32'(hours_left), 0);
    tick();
    chk_dig("load 13:47", 1, 3, 4, 7);
    chk("load cursor", 32'(cursor), 0);
    chk("load ack", 32'(set_time_ack_flag), 0);
    chk("load active", 32'(set_time_active), 0);
    tick(); tick(); tick();
    chk("blink before period", 32'(blink), 0);
    tick();
    chk("blink after period", 32'(blink), 1);
    press(1'b1, 1'b0);
    chk_dig("inc HL 1->2", 2, 3, 4, 7);
    chk("inc clears blink", 32'(blink), 0);
    chk("inc sets active", 32'(set_time_active), 1);

    // 19:00 -> HL inc clamps HR, second inc wraps HL.
    start(19, 0);
    chk("reload clears active", 32'(set_time_active), 0);
    press(1'b1, 1'b0);
    chk_dig("HL clamp", 2, 3, 0, 0);
    chk("clamp active", 32'(set_time_active), 1);
    press(1'b1, 1'b0);
    chk_dig("HL wrap", 0, 3, 0, 0);

    // 23:59 -> HR wraps at 3, ML wraps at 5.
    start(23, 59);
    press(1'b0, 1'b1);
    chk("cursor HR", 32'(cursor), 1);
    press(1'b1, 1'b0);
    chk_dig("HR wrap", 2, 0, 5, 9);
    press(1'b0, 1'b1);
    chk("cursor ML", 32'(cursor), 2);
    press(1'b1, 1'b0);
    chk_dig("ML wrap", 2, 0, 0, 9);

    // Completion handshake with no edits.
    start(8, 5);
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    chk("cursor MR", 32'(cursor), 3);
    chk("ack before done", 32'(set_time_ack_flag), 0);
    press(1'b0, 1'b1);
    chk("done ack", 32'(set_time_ack_flag), 1);
    chk("done active", 32'(set_time_active), 0);
    chk("done cursor", 32'(cursor), 0);
    press(1'b1, 1'b0);
    chk_dig("done ignores inc", 0, 8, 0, 5);
    chk("done ack held", 32'(set_time_ack_flag), 1);
    en = 1'b0;
    tick();
    chk("idle ack", 32'(set_time_ack_flag), 0);
    chk_dig("idle retains", 0, 8, 0, 5);
    press(1'b1, 1'b1);
    chk_dig("idle ignores inc", 0, 8, 0, 5);
    chk("idle cursor", 32'(cursor), 0);

    // Out-of-range hours, then simultaneous inc+next on MR=9.
    start(30, 9);
    chk_dig("hours 30", 0, 0, 0, 9);
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    press(1'b1, 1'b1);
    chk_dig("MR wrap+next", 0, 0, 0, 0);
    chk("simul ack", 32'(set_time_ack_flag), 1);
    chk("simul active", 32'(set_time_active), 1);
    start(12, 60);
    chk_dig("minutes 60", 1, 2, 0, 0);

    // Asynchronous reset mid-edit.
    start(12, 34);
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk_dig("async rst", 0, 0, 0, 0);
    chk("async rst cursor", 32'(cursor), 0);
    chk("async rst blink", 32'(blink), 0);
    tick();
    rst = 1'b0;
    tick();
    chk("post-rst LOAD HL", 32'(hours_left), 0);
    chk("post-rst LOAD cursor", 32'(cursor), 0);
    tick();
    chk_dig("post-rst reload", 1, 2, 3, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
